mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants while fetch waits.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum wait, in cycles, for m_ready.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port if_req, input, 1 bit: instruction-fetch read request.
REQ-006 SHALL have port if_addr, input, 16 bits: fetch address (PC).
REQ-007 SHALL have port if_gnt, output, 1 bit: fetch request accepted (one-cycle pulse).
REQ-008 SHALL have port if_rvalid, output, 1 bit: fetch data valid (one-cycle pulse).
REQ-009 SHALL have port if_rdata, output, 16 bits: fetched instruction.
REQ-010 SHALL have port d_req, input, 1 bit: data-access request.
REQ-011 SHALL have port d_we, input, 1 bit: data write enable (1 = write).
REQ-012 SHALL have port d_addr, input, 16 bits: data address.
REQ-013 SHALL have port d_wdata, input, 16 bits: write data.
REQ-014 SHALL have port d_gnt, output, 1 bit: data request accepted (one-cycle pulse).
REQ-015 SHALL have port d_rvalid, output, 1 bit: read data valid or write acknowledge (one-cycle pulse).
REQ-016 SHALL have port d_rdata, output, 16 bits: read data.
REQ-017 SHALL have port m_req, output, 1 bit: memory request.
REQ-018 SHALL have port m_we, output, 1 bit: memory write enable.
REQ-019 SHALL have port m_addr, output, 16 bits: memory address.
REQ-020 SHALL have port m_wdata, output, 16 bits: memory write data.
REQ-021 SHALL have port m_ready, input, 1 bit: memory completes the transfer this cycle.
REQ-022 SHALL have port m_rdata, input, 16 bits: memory read data, valid when m_ready is high.
REQ-023 SHALL have port err, output, 1 bit: timeout pulse.

Function
REQ-024 SHALL implement the states IDLE, BUSY_IF and BUSY_D.
REQ-025 In IDLE with at least one request pending, SHALL at the next edge go to BUSY_IF or BUSY_D, pulse the matching gnt for exactly one cycle, and capture addr, we and wdata.
REQ-026 SHALL give d_req priority over if_req, except that fetch wins when the starvation count equals STARVE_LIMIT.
REQ-027 Starvation count: increments on each data grant while if_req is high, clears on a fetch grant or when if_req is low, and saturates at STARVE_LIMIT.
REQ-028 In the BUSY states, SHALL hold m_req=1 with m_addr, m_we and m_wdata stable from the captured values until the cycle in which m_ready is sampled high.
REQ-029 A fetch SHALL always drive m_we=0.
REQ-030 On m_ready, SHALL register m_rdata into the owner's rdata and pulse the owner's rvalid in the next cycle, and return to IDLE at that edge.
REQ-031 Minimum latency: request in cycle 0, gnt in cycle 1, m_ready in cycle 1, rvalid in cycle 2.
REQ-032 The next grant SHALL come no earlier than the cycle after rvalid.
REQ-033 On a write, d_rvalid SHALL pulse as the acknowledge and d_rdata SHALL hold its previous value.
REQ-034 A requester may drop req after its gnt; the transaction SHALL still complete.
REQ-035 rdata outputs SHALL hold their values between rvalid pulses.
REQ-036 A wait counter SHALL clear on entry to a BUSY state and increment each BUSY cycle without m_ready.
REQ-037 When the wait counter reaches TIMEOUT, SHALL drop m_req, pulse err for one cycle, return to IDLE, and pulse no rvalid.
REQ-038 m_ready while IDLE SHALL be ignored.
REQ-039 if_req and d_req both newly high in IDLE with starvation count below STARVE_LIMIT: data SHALL be granted.

Reset
REQ-040 On rst, SHALL asynchronously force state IDLE and drive all outputs to 0 (gnt, rvalid, rdata, m_* and err).
REQ-041 On rst, SHALL clear the starvation and wait counters.
REQ-042 Reset during a BUSY state SHALL abort the transfer with no rvalid and no err.
REQ-043 The first grant after reset release SHALL occur no earlier than the second rising edge after release.

Structure
REQ-044 The state encoding, the 16-bit data/address width constant and the STARVE_LIMIT/TIMEOUT defaults SHALL be in the shared package proc_pkg.
REQ-045 The wait counter with timeout compare SHALL be the single sub-module arb_timer (clear, enable, expired); all other logic SHALL be inline.

Verification
REQ-046 Fetch only: if_req=1, if_addr=0x0004, m_ready high in the gnt cycle with m_rdata=0x2275 -> if_gnt in cycle 1, if_rvalid in cycle 2, if_rdata=0x2275.
REQ-047 Simultaneous requests: if_req=d_req=1 held, d_we=1, d_addr=0x0010, d_wdata=0x2277 -> d_gnt first, m_we=1, m_wdata=0x2277, d_rvalid ack, then if_gnt.
REQ-048 Starvation: if_req high, d_req re-asserted after every d_rvalid -> exactly 4 data grants, then 1 fetch grant, then data again.
REQ-049 Wait states: m_ready delayed 3 cycles -> m_req and m_addr stable for 4 cycles, single rvalid, no err.
REQ-050 Timeout: m_ready held low -> err pulse after 15 BUSY cycles, m_req=0, state IDLE, no rvalid.
REQ-051 Reset mid-transfer: rst asserted in the second BUSY_D cycle -> m_req=0 immediately, no d_rvalid, and a normal fetch completes after release.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants and state encoding for the memory arbiter.
package proc_pkg;

  localparam int DATA_W           = 16;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int TIMEOUT_DEF      = 15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_timer.sv
// Memory wait counter; flags the cycle in which the TIMEOUT-th wait without m_ready occurs.
module arb_timer
  import proc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = i_enable && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between instruction fetch and data access:
// data has priority, fetch is protected from starvation, stalled transfers time out.
module mem_arbiter
  import proc_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int TIMEOUT      = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t        r_state, w_state_nxt;
  logic              r_armed;
  logic [SW-1:0]     r_starve;
  logic [DATA_W-1:0] r_addr, r_wdata, r_if_rdata, r_d_rdata;
  logic              r_we, r_if_gnt, r_d_gnt, r_if_rvalid, r_d_rvalid, r_err;
  logic              w_busy, w_starved, w_gnt_if, w_gnt_d;
  logic              w_done_if, w_done_d, w_timeout, w_expired;

  assign w_busy    = (r_state != IDLE);
  assign w_starved = (r_starve == SW'(STARVE_LIMIT));

  arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_gnt_if || w_gnt_d),
    .i_enable (w_busy && !m_ready),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // r_armed holds off arbitration for the first edge after reset release.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_if    = 1'b0;
    w_gnt_d     = 1'b0;
    w_done_if   = 1'b0;
    w_done_d    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_armed) begin
          if (d_req && !(if_req && w_starved)) begin
            w_gnt_d     = 1'b1;
            w_state_nxt = BUSY_D;
          end else if (if_req) begin
            w_gnt_if    = 1'b1;
            w_state_nxt = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_D: begin
        if (m_ready) begin
          w_done_if   = (r_state == BUSY_IF);
          w_done_d    = (r_state == BUSY_D);
          w_state_nxt = IDLE;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed     <= 1'b0;
      r_starve    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_gnt    <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_armed     <= 1'b1;
      r_if_gnt    <= w_gnt_if;
      r_d_gnt     <= w_gnt_d;
      r_if_rvalid <= w_done_if;
      r_d_rvalid  <= w_done_d;
      r_err       <= w_timeout;
      if (w_gnt_d) begin
        r_addr  <= d_addr;
        r_we    <= d_we;
        r_wdata <= d_wdata;
      end else if (w_gnt_if) begin
        r_addr  <= if_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
      end
      if (w_done_if)          r_if_rdata <= m_rdata;
      if (w_done_d && !r_we)  r_d_rdata  <= m_rdata;
      if (w_gnt_if || !if_req)          r_starve <= '0;
      else if (w_gnt_d && !w_starved)   r_starve <= r_starve + SW'(1);
    end
  end

  assign if_gnt    = r_if_gnt;
  assign d_gnt     = r_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign err       = r_err;
  assign m_req     = w_busy;
  assign m_we      = r_we;
  assign m_addr    = r_addr;
  assign m_wdata   = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int STARVE = 4;
  localparam int TO     = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, m_ready;
  logic [15:0] if_addr, d_addr, d_wdata, m_rdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, m_req, m_we, err;
  logic [15:0] if_rdata, d_rdata, m_addr, m_wdata;

  mem_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %b, want %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d, want %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: owner 0 = nobody, 1 = fetch, 2 = data.
  int          mdl_owner = 0, mdl_waits = 0, mdl_starve = 0;
  bit          mdl_armed = 1'b0, mdl_gi, mdl_gd;
  logic [15:0] mdl_addr = '0, mdl_wdata = '0;
  logic        mdl_we = 1'b0;
  logic        e_if_gnt = 0, e_d_gnt = 0, e_if_rv = 0, e_d_rv = 0, e_err = 0;
  logic [15:0] e_if_rdata = '0, e_d_rdata = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mdl_owner = 0; mdl_waits = 0; mdl_starve = 0; mdl_armed = 1'b0;
      mdl_addr = '0; mdl_wdata = '0; mdl_we = 1'b0;
      e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0; e_err = 0;
      e_if_rdata = '0; e_d_rdata = '0;
    end else begin
      mdl_gi = 1'b0; mdl_gd = 1'b0;
      e_if_rv = 0; e_d_rv = 0; e_err = 0;
      if (mdl_owner == 0) begin
        if (mdl_armed) begin
          if (d_req && !(if_req && mdl_starve == STARVE)) mdl_gd = 1'b1;
          else if (if_req)                                 mdl_gi = 1'b1;
        end
        if (mdl_gd) begin
          mdl_owner = 2; mdl_addr = d_addr; mdl_we = d_we; mdl_wdata = d_wdata; mdl_waits = 0;
        end else if (mdl_gi) begin
          mdl_owner = 1; mdl_addr = if_addr; mdl_we = 1'b0; mdl_waits = 0;
        end
      end else if (m_ready) begin
        if (mdl_owner == 1) begin
          e_if_rv = 1; e_if_rdata = m_rdata;
        end else begin
          e_d_rv = 1;
          if (!mdl_we) e_d_rdata = m_rdata;
        end
        mdl_owner = 0;
      end else begin
        mdl_waits++;
        if (mdl_waits == TO) begin
          e_err = 1; mdl_owner = 0;
        end
      end
      e_if_gnt = mdl_gi;
      e_d_gnt  = mdl_gd;
      if (mdl_gi || !if_req)                  mdl_starve = 0;
      else if (mdl_gd && mdl_starve < STARVE) mdl_starve++;
      mdl_armed = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk1("if_gnt", if_gnt, e_if_gnt);
      chk1("d_gnt", d_gnt, e_d_gnt);
      chk1("if_rvalid", if_rvalid, e_if_rv);
      chk1("d_rvalid", d_rvalid, e_d_rv);
      chk1("err", err, e_err);
      chk16("if_rdata", if_rdata, e_if_rdata);
      chk16("d_rdata", d_rdata, e_d_rdata);
      chk1("m_req", m_req, mdl_owner != 0);
      if (mdl_owner != 0 || rst) begin
        chk16("m_addr", m_addr, mdl_addr);
        chk1("m_we", m_we, mdl_we);
        if (mdl_we || rst) chk16("m_wdata", m_wdata, mdl_wdata);
      end
    end
  end

  // Memory responder: m_ready after a programmable number of wait cycles, noise while idle.
  int          mem_delay = 0, cur_delay = 0, bcnt = 0;
  bit          rand_mode = 1'b0, use_fixed = 1'b0;
  logic [15:0] fixed_rdata = '0;

  initial begin
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (m_req) begin
        if (bcnt == 0) begin
          if (rand_mode) begin
            cur_delay = $urandom_range(0, 19);
            cur_delay = (cur_delay == 0) ? 99 : cur_delay % 4;
          end else begin
            cur_delay = mem_delay;
          end
        end
        m_ready = (bcnt == cur_delay);
        bcnt++;
      end else begin
        bcnt    = 0;
        m_ready = ($urandom_range(0, 3) == 0);
      end
      m_rdata = use_fixed ? fixed_rdata : 16'($urandom);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && m_req; i++) tick();
    tick();
  endtask

  int seq[$];
  int exp_seq[6] = '{2, 2, 2, 2, 1, 2};
  int busy, rv, errs, drv;
  bit seen;

  initial begin
    rst = 1'b1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    use_fixed = 1'b1; fixed_rdata = 16'h2275; mem_delay = 0;
    tick();
    chk_en = 1'b1;
    tick(); tick();

    // Reset release, hold-off, then fetch-only transactions back to back.
    rst = 1'b0; if_req = 1'b1; if_addr = 16'h0004;
    tick();
    chk1("gnt_first_edge_after_rst", if_gnt, 1'b0);
    tick();
    chk1("fetch_gnt", if_gnt, 1'b1);
    chk16("fetch_m_addr", m_addr, 16'h0004);
    chk1("fetch_m_we", m_we, 1'b0);
    tick();
    chk1("fetch_rvalid", if_rvalid, 1'b1);
    chk16("fetch_rdata", if_rdata, 16'h2275);
    chk1("no_gnt_in_rvalid_cycle", if_gnt, 1'b0);
    tick();
    chk1("fetch_gnt_after_rvalid", if_gnt, 1'b1);
    if_req = 1'b0;
    tick();
    chk1("fetch2_rvalid", if_rvalid, 1'b1);

    // Simultaneous requests: data write first, then fetch.
    if_req = 1'b1; if_addr = 16'h0020;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'h2277;
    tick();
    chk1("simul_d_gnt", d_gnt, 1'b1);
    chk1("simul_if_gnt_low", if_gnt, 1'b0);
    chk1("simul_m_we", m_we, 1'b1);
    chk16("simul_m_wdata", m_wdata, 16'h2277);
    chk16("simul_m_addr", m_addr, 16'h0010);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk1("write_ack", d_rvalid, 1'b1);
    chk16("write_keeps_d_rdata", d_rdata, 16'h0000);
    tick();
    chk1("simul_then_if_gnt", if_gnt, 1'b1);
    chk16("simul_if_m_addr", m_addr, 16'h0020);
    if_req = 1'b0;
    tick();
    chk1("simul_if_rvalid", if_rvalid, 1'b1);

    // Starvation: both requests held.
    use_fixed = 1'b0;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100; if_addr = 16'h0200;
    for (int i = 0; i < 30 && seq.size() < 6; i++) begin
      tick();
      if (d_gnt)  seq.push_back(2);
      if (if_gnt) seq.push_back(1);
    end
    if_req = 1'b0; d_req = 1'b0;
    drain();
    chki("starve_grant_count", seq.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < seq.size()) chki("starve_grant_order", seq[k], exp_seq[k]);

    // Wait states: three cycles of memory delay.
    mem_delay = 3;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
    tick();
    chk1("wait_d_gnt", d_gnt, 1'b1);
    d_req = 1'b0;
    busy = (m_req && m_addr == 16'h0030) ? 1 : 0; rv = 0; errs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m_req && m_addr == 16'h0030) busy++;
      if (d_rvalid) rv++;
      if (err) errs++;
    end
    chki("wait_busy_cycles", busy, 4);
    chki("wait_rvalid_count", rv, 1);
    chki("wait_err_count", errs, 0);

    // Timeout: memory never answers.
    mem_delay = 99;
    if_req = 1'b1; if_addr = 16'h0040;
    tick();
    chk1("to_if_gnt", if_gnt, 1'b1);
    if_req = 1'b0;
    busy = m_req ? 1 : 0; rv = 0; errs = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (m_req) busy++;
      if (if_rvalid) rv++;
      if (err) begin
        errs++;
        chk1("to_m_req_at_err", m_req, 1'b0);
      end
    end
    chki("to_busy_cycles", busy, 15);
    chki("to_err_count", errs, 1);
    chki("to_rvalid_count", rv, 0);

    // Reset in the second data busy cycle, then a normal fetch.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0060;
    tick();
    chk1("rstmid_d_gnt", d_gnt, 1'b1);
    d_req = 1'b0;
    tick();
    chk1("rstmid_busy2_m_req", m_req, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rstmid_m_req_async", m_req, 1'b0);
    chk16("rstmid_m_addr_async", m_addr, 16'h0000);
    tick(); tick();
    rst = 1'b0; mem_delay = 0; use_fixed = 1'b1; fixed_rdata = 16'h1234;
    if_req = 1'b1; if_addr = 16'h0050;
    seen = 1'b0; drv = 0; errs = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (if_gnt) if_req = 1'b0;
      if (d_rvalid) drv++;
      if (err) errs++;
      if (if_rvalid) begin
        seen = 1'b1;
        chk16("rstmid_fetch_rdata", if_rdata, 16'h1234);
      end
    end
    chk1("rstmid_fetch_completed", seen, 1'b1);
    chki("rstmid_no_d_rvalid", drv, 0);
    chki("rstmid_no_err", errs, 0);

    // Randomised traffic with occasional asynchronous resets.
    use_fixed = 1'b0; rand_mode = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      rst     = ($urandom_range(0, 399) == 0);
      if_req  = ($urandom_range(0, 9) < 6);
      d_req   = ($urandom_range(0, 9) < 5);
      d_we    = $urandom_range(0, 1) == 1;
      if_addr = 16'($urandom);
      d_addr  = 16'($urandom);
      d_wdata = 16'($urandom);
      tick();
    end
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; rand_mode = 1'b0;
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
